// File: rtl/countdown_arbiter_pkg.sv
// Shared definitions for the countdown arbiter: FSM state encoding,
// default sizing constants and a one-hot to index helper.
// No logic of its own.
package countdown_arbiter_pkg;

  localparam int CNTARB_N_DEF = 4;  // default number of requesters
  localparam int CNTARB_W_DEF = 4;  // default counter width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Index of the set bit in a one-hot vector (up to 8 requesters).
  // A zero vector returns 0.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/countdown_arbiter_load_down_counter.sv
// Loadable W-bit down-counter that saturates at zero.
// Latency: load/decrement visible one cycle after the edge; no backpressure.
// Ports: i_clk, i_rst (sync, active-high), i_load/i_load_val (synchronous
//        load, wins over decrement), i_dec (decrement), o_value, o_zero.
module countdown_arbiter_load_down_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_value,
  output logic         o_zero
);

  logic [W-1:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_dec && (r_value != '0)) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign o_value = r_value;
  assign o_zero  = (r_value == '0);

endmodule

// File: rtl/countdown_arbiter.sv
// Round-robin arbiter sharing one loadable down-counter between N requesters.
// Latency: Req seen in IDLE -> Grant next cycle; Done L+2 cycles after Req
// sample; free at L+3. Requesters are held off (no grant) while busy.
// Ports: i_clk, i_rst (sync, active-high), i_req[N] (level, hold until Done),
//        i_data_in[N*W] (slice i = load value of requester i), o_grant[N]
//        (one-hot owner), o_done[N] (one-cycle pulse), o_busy, o_count_out[W].
// Build option: define CNTARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, no rotating pointer).
module countdown_arbiter
  import countdown_arbiter_pkg::*;
#(
  parameter int N = CNTARB_N_DEF,
  parameter int W = CNTARB_W_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_req,
  input  logic [N*W-1:0] i_data_in,
  output logic [N-1:0]   o_grant,
  output logic [N-1:0]   o_done,
  output logic           o_busy,
  output logic [W-1:0]   o_count_out
);

  state_t       r_state;
  logic [N-1:0] r_grant;
  logic [N-1:0] r_done;
  logic         r_busy;

  logic [2:0]   w_ptr;
  logic [N-1:0] w_win_oh;
  logic [W-1:0] w_load_val;
  logic         w_load;
  logic         w_dec;
  logic [W-1:0] w_value;
  logic         w_zero;
  logic         w_owner_req;

`ifdef CNTARB_FIXED_PRIO_EN
  assign w_ptr = 3'd0;
`else
  logic [2:0] r_ptr;
  logic [2:0] r_owner;
  logic [2:0] w_ptr_nxt;
  logic [2:0] w_win_idx;
  logic [7:0] w_win_ext;

  assign w_ptr = r_ptr;

  always_comb begin
    w_win_ext = '0;
    for (int i = 0; i < N; i++) w_win_ext[i] = w_win_oh[i];
  end

  assign w_win_idx = onehot_to_idx(w_win_ext);
  assign w_ptr_nxt = (r_owner == 3'(N-1)) ? 3'd0 : (r_owner + 3'd1);
`endif

  // Winner = requester with the smallest rotational distance from the
  // pointer. Distances are unique, so exactly one bit wins when any is set.
  always_comb begin
    int best_d;
    int d;
    best_d   = N;
    w_win_oh = '0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(w_ptr);
      if (d < 0) d = d + N;
      if (i_req[i] && (d < best_d)) best_d = d;
    end
    for (int i = 0; i < N; i++) begin
      d = i - int'(w_ptr);
      if (d < 0) d = d + N;
      w_win_oh[i] = i_req[i] && (d == best_d);
    end
  end

  always_comb begin
    w_load_val = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win_oh[i]) w_load_val = i_data_in[i*W +: W];
    end
  end

  // Owner still requesting; dropping it mid-count aborts the tenure.
  assign w_owner_req = |(i_req & r_grant);

  assign w_load = (r_state == ST_IDLE) && (|i_req);
  assign w_dec  = (r_state == ST_COUNT);

  countdown_arbiter_load_down_counter #(.W(W)) u_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_value    (w_value),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
`ifndef CNTARB_FIXED_PRIO_EN
      r_ptr   <= 3'd0;
      r_owner <= 3'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= '0;
          if (|i_req) begin
            r_grant <= w_win_oh;
            r_busy  <= 1'b1;
            r_state <= ST_COUNT;
`ifndef CNTARB_FIXED_PRIO_EN
            r_owner <= w_win_idx;
`endif
          end
        end
        ST_COUNT: begin
          // Abort takes precedence over reaching zero: no Done is owed
          // to a requester that has already walked away.
          if (!w_owner_req) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
`ifndef CNTARB_FIXED_PRIO_EN
            r_ptr   <= w_ptr_nxt;
`endif
          end else if (w_zero) begin
            r_done  <= r_grant;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
`ifndef CNTARB_FIXED_PRIO_EN
          r_ptr   <= w_ptr_nxt;
`endif
        end
        default: begin
          r_done  <= '0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_grant     = r_grant;
  assign o_done      = r_done;
  assign o_busy      = r_busy;
  // Counter may hold a stale value after an abort; hide it while free.
  assign o_count_out = r_busy ? w_value : '0;

endmodule

// File: tb/tb_countdown_arbiter.sv
module tb_countdown_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count_out;

  countdown_arbiter #(.N(N), .W(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_data_in   (data),
    .o_grant     (grant),
    .o_done      (done),
    .o_busy      (busy),
    .o_count_out (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    int           len;
    int           abort;  // -1: runs to Done, else COUNT index where Req drops
  } tenure_t;

  tenure_t q[$];
  int tests = 0;
  int fails = 0;
  int issued = 0;
  int ended = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected tenure when a grant appears and follows
  // its timeline cycle by cycle.
  initial begin
    bit      in_ten;
    int      j;
    tenure_t e;
    in_ten = 1'b0;
    j = 0;
    e.g = '0; e.len = 0; e.abort = -1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!in_ten && grant != '0) begin
          if (q.size() == 0) begin
            check("unexpected_grant", 32'(grant), 32'd0);
            e.g = grant; e.len = 0; e.abort = -1;
          end else begin
            e = q.pop_front();
            check("grant_owner", 32'(grant), 32'(e.g));
          end
          in_ten = 1'b1;
          j = 0;
        end
        if (in_ten) begin
          if (e.abort >= 0 && j == e.abort + 1) begin
            check("abort_release", {grant, done, 3'b0, busy, count_out}, 32'd0);
            in_ten = 1'b0;
            ended++;
          end else if (j <= e.len) begin
            check("count_value", 32'(count_out), 32'(e.len - j));
            check("count_state", {grant, done, 3'b0, busy}, {e.g, 4'd0, 4'd1});
          end else if (j == e.len + 1) begin
            check("done_pulse", {grant, done, 3'b0, busy, count_out}, {e.g, e.g, 4'd1, 4'd0});
          end else begin
            check("release", {grant, done, 3'b0, busy, count_out}, 32'd0);
            in_ten = 1'b0;
            ended++;
          end
          j++;
        end else begin
          check("idle", {grant, done, 3'b0, busy, count_out}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int ptr = 0;

  function automatic int pick_winner(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial begin
    logic [N-1:0] mask;
    int win, len, ab;
    tenure_t t;

    // Reset with all requests pending.
    rst = 1'b1;
    req = 4'b1111;
    data = 16'h5A3C;
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", {grant, done, 3'b0, busy, count_out}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    check("after_reset", {grant, done, 3'b0, busy, count_out}, 32'd0);

    // Randomized tenures checked by the monitor.
    mon_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      data = N*W'($urandom);
      mask = N'($urandom_range(1, (1 << N) - 1));
      ab = -1;
      if (n == 0) begin
        mask = 4'b0010;
        data[1*W +: W] = 4'd15;
      end else if (n <= 5) begin
        mask = 4'b1111;
        data = '0;
      end else if ($urandom_range(0, 3) == 0) begin
        ab = 0;  // resolved below once L is known
      end
`ifdef CNTARB_FIXED_PRIO_EN
      win = pick_winner(mask, 0);
`else
      win = pick_winner(mask, ptr);
`endif
      len = int'(data[win*W +: W]);
      if (ab == 0) ab = $urandom_range(0, len);
      t.g = N'(1 << win); t.len = len; t.abort = ab;
      q.push_back(t);
      issued++;
      req = mask;
`ifndef CNTARB_FIXED_PRIO_EN
      ptr = (win + 1) % N;
`endif
      // Cycle 1: perturb load values and other requests; must be ignored.
      @(posedge clk); #1;
      data = N*W'($urandom);
      req = req | N'($urandom);
      if (ab >= 0) begin
        repeat (ab) @(posedge clk);
        #1;
        req = '0;
      end else begin
        repeat (len + 1) @(posedge clk);
        #1;
        req = '0;
      end
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    check("all_tenures_ended", 32'(ended), 32'(issued));
    check("queue_empty", 32'(q.size()), 32'd0);

    // Reset in the middle of a count aborts and clears the pointer.
    @(posedge clk); #1;
    req = 4'b0100;
    data = '0;
    data[2*W +: W] = 4'd12;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("midcount_value", 32'(count_out), 32'd7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    check("midreset_idle", {grant, done, 3'b0, busy, count_out}, 32'd0);
    @(negedge clk);
    check("post_reset_grant", 32'(grant), 32'd1);
    check("post_reset_done", 32'(done), 32'd0);
    req = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown_arbiter.md
Name: countdown_arbiter

Overview:
- Shares one loadable W-bit down-counter between N requesters.
- Each requester presents a load value and asserts a request.
- The arbiter picks a requester round-robin, loads its value into the counter and sequences the countdown to zero.
- It then pulses Done to the owner and releases the counter.
- Sits between multiple timing/delay clients and the single shared counter datapath.

Parameters:
- N, 4, number of requesters (2..8).
- W, 4, counter/load-value width in bits.

Ports:
- Clk  input  1  system clock, all state updates on posedge.
- Rst  input  1  synchronous, active-high reset.
- Req  input  N  per-requester request, level; must stay high until Done.
- DataIn  input  N*W  packed load values; slice i = DataIn[i*W +: W].
- Grant  output  N  one-hot owner of the counter; all zero when free.
- Done  output  N  one-cycle pulse to the owner when its count reaches zero.
- Busy  output  1  high while any requester owns the counter.
- CountOut  output  W  current counter value; 0 when idle.

Behaviour:
- Interface: one clock (Clk); reset (Rst) is synchronous and active-high.
- Reset values: Grant=0, Done=0, Busy=0, CountOut=0, state=IDLE, round-robin pointer=0.
- Reset asserted mid-operation aborts the tenure: no Done, back to IDLE on the next edge.
- States: IDLE, COUNT, DONE.
- IDLE, Req==0: stay in IDLE; outputs as reset.
- IDLE, Req!=0: winner = first set bit scanning from pointer upward, mod N. On the next edge:
  - Grant=onehot(winner), Busy=1.
  - counter <= DataIn slice(winner).
  - state=COUNT.
- COUNT:
  - CountOut shows counter; counter decrements by 1 each cycle.
  - When counter==0, next state=DONE and the counter holds at 0. No wrap below zero.
  - COUNT lasts L+1 cycles for load value L; CountOut sequence is L, L-1, ..., 0.
  - L=0 gives one COUNT cycle.
- DONE:
  - Done[winner]=1 for exactly one cycle; Grant and Busy held.
  - Next state=IDLE; pointer <= (winner+1) mod N.
- Leaving DONE: Grant=0, Busy=0, CountOut=0. The requester must drop Req on or before Done.
  - If Req is still high in IDLE, it re-competes at lowest priority.
- Abort: Req[winner] low during COUNT.
  - Next edge: IDLE, Grant=0, Busy=0, no Done pulse.
  - pointer <= winner+1.
- Timing:
  - Req sampled in IDLE at cycle 0 → Grant at cycle 1.
  - Done at cycle L+2.
  - Free at cycle L+3.
  - Earliest next Grant at cycle L+4.
- New requests and DataIn changes during COUNT/DONE are ignored; the load value is captured only on the IDLE→COUNT edge.
- Done and Grant are registered outputs, never combinational from Req.

Optional Feature:
- Macro: CNTARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is not implemented and always reads as 0.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'd0, COUNT=2'd1, DONE=2'd2;
  - default N and W constants;
  - a one-hot-to-index function.
- One sub-module: load_down_counter.
  - Ports: Clk, Rst, Load, LoadVal[W], Dec, Value[W], Zero.
  - Behaviour: synchronous load; decrement saturating at 0.
- The arbiter contains only the FSM, pointer and winner select.

Test Plan:
- Reset: Rst=1 for 2 cycles with Req=4'b1111 → Grant=0, Done=0, Busy=0, CountOut=0 throughout and one cycle after release.
- Single request: Req=4'b0001, slice0=3 at cycle 0 → Grant=0001 at cycle 1; CountOut 3,2,1,0 on cycles 1–4; Done=0001 at cycle 5; Grant=0 at cycle 6.
- Round-robin: Req=4'b1111 held, all slices=0 → grant order 0001,0010,0100,1000,0001. Each tenure is 1 COUNT + 1 DONE cycle. With CNTARB_FIXED_PRIO_EN, always 0001.
- Abort: Req=0100, slice2=9; drop Req[2] when CountOut=5 → next cycle Grant=0, Busy=0, Done never pulses. A subsequent Req=1100 is granted 1000 first.
- Max load: slice1=15 → 16 COUNT cycles (15..0), Done at cycle 17, CountOut never shows 15 after reaching 0.
- Reset mid-count: Rst=1 while CountOut=7 → IDLE next edge, no Done, pointer=0. A following Req=1111 is granted 0001.
